// File: rtl/w_mem_reader.sv
// w_mem_reader: streams weights 0..numWeight-1 from a registered-read memory over valid/ready
module w_mem_reader #(
  parameter int numWeight    = 30,
  parameter int addressWidth = (numWeight > 1) ? $clog2(numWeight) : 1,
  parameter int dataWidth    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_ren,
  output logic [addressWidth-1:0] mem_radd,
  input  logic [dataWidth-1:0]    mem_rdata,
  output logic                    w_valid,
  input  logic                    w_ready,
  output logic [dataWidth-1:0]    w_data,
  output logic                    w_last
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [addressWidth-1:0] LAST_ADDR = addressWidth'(numWeight - 1);
  state_t                  state_q, state_d;
  logic [addressWidth-1:0] addr_q, addr_d;
  logic                    ren_q, tag_q, tag_d;
  logic [1:0]              occ_q, occ_d;
  logic [dataWidth:0]      buf0_q, buf1_q, buf0_d, buf1_d;
  logic [dataWidth:0]      e0, e1, e2;
  logic                    pop;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      ren_q   <= 1'b0;
      tag_q   <= 1'b0;
      occ_q   <= '0;
      buf0_q  <= '0;
      buf1_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ren_q   <= mem_ren;
      tag_q   <= tag_d;
      occ_q   <= occ_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
    end
  end
  // The read in flight is viewed as the entry behind the stored ones, so its data can be offered immediately.
  always_comb begin
    e2       = {mem_rdata, tag_q};
    e0       = (occ_q != 2'd0) ? buf0_q : e2;
    e1       = (occ_q > 2'd1) ? buf1_q : e2;
    w_valid  = (occ_q != 2'd0) || ren_q;
    w_data   = w_valid ? e0[dataWidth:1] : '0;
    w_last   = w_valid & e0[0];
    pop      = w_valid & w_ready;
    mem_ren  = (state_q == RUN) && (({1'b0, occ_q} + 3'(ren_q) - 3'(pop)) < 3'd2);
    mem_radd = addr_q;
    busy     = state_q != IDLE;
    done     = state_q == DONE;
  end
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && start) state_d = RUN;
    if (state_q == RUN && mem_ren && addr_q == LAST_ADDR) state_d = DRAIN;
    if (state_q == DRAIN && pop && e0[0]) state_d = DONE;
    if (state_q == DONE) state_d = IDLE;
  end
  always_comb begin
    addr_d = (state_q == IDLE && start) ? '0 :
             (mem_ren && addr_q != LAST_ADDR) ? addr_q + 1'b1 : addr_q;
    tag_d  = mem_ren && addr_q == LAST_ADDR;
    occ_d  = occ_q + {1'b0, ren_q} - {1'b0, pop};
    buf0_d = pop ? e1 : e0;
    buf1_d = pop ? e2 : e1;
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(occ_q == 2'd2 && ren_q && !pop));
endmodule

// File: tb/tb_w_mem_reader.sv
// tb_w_mem_reader: random-data scoreboard bench for w_mem_reader (30-weight and 1-weight builds)
module tb_w_mem_reader;
  localparam int N = 30;
  logic        clk = 1'b0;
  logic        rst, start, w_ready, start1, ready1;
  logic        busy, done, mem_ren, w_valid, w_last;
  logic [4:0]  mem_radd;
  logic [15:0] mem_rdata, w_data;
  logic        busy1, done1, mem_ren1, w_valid1, w_last1;
  logic [0:0]  mem_radd1;
  logic [15:0] mem_rdata1, w_data1;
  logic [15:0] mem [N];
  logic [15:0] mem1;
  int vectors = 0, errors = 0, cyc = 0;
  int idx, iss, acc, n_done, first_v, last_c, done_c;
  bit stall_prev;
  logic [15:0] prev_data;
  logic prev_last;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_radd];
  always @(posedge clk) if (mem_ren1) mem_rdata1 <= mem1;

  w_mem_reader #(.numWeight(N), .dataWidth(16)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .mem_ren(mem_ren),
    .mem_radd(mem_radd), .mem_rdata(mem_rdata), .w_valid(w_valid), .w_ready(w_ready),
    .w_data(w_data), .w_last(w_last));
  w_mem_reader #(.numWeight(1), .dataWidth(16)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .mem_ren(mem_ren1),
    .mem_radd(mem_radd1), .mem_rdata(mem_rdata1), .w_valid(w_valid1), .w_ready(ready1),
    .w_data(w_data1), .w_last(w_last1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: beats must be mem[0..N-1] in order, reads ascending, at most 2 outstanding.
  always @(negedge clk) if (!rst) begin
    if (stall_prev) begin
      chk("stall_valid", 32'(w_valid), 32'd1);
      chk("stall_data", 32'(w_data), 32'(prev_data));
      chk("stall_last", 32'(w_last), 32'(prev_last));
    end
    if (mem_ren) begin
      chk("radd", 32'(mem_radd), 32'(iss));
      iss++;
    end
    if (w_valid && first_v < 0) first_v = cyc;
    if (w_valid && w_ready) begin
      chk("data", 32'(w_data), (idx < N) ? 32'(mem[idx]) : 32'hdead);
      chk("last", 32'(w_last), 32'(idx == N - 1));
      last_c = cyc;
      idx++;
      acc++;
    end
    chk("outstanding_le2", 32'(iss - acc <= 2), 32'd1);
    if (done) begin
      n_done++;
      done_c = cyc;
    end
    stall_prev = w_valid && !w_ready;
    prev_data = w_data;
    prev_last = w_last;
  end

  task automatic clear_sb();
    idx = 0; iss = 0; acc = 0; n_done = 0; first_v = -1; last_c = -1; done_c = -1;
    stall_prev = 1'b0;
  endtask

  // mode 0: ready high, 1: alternating, 2: held low for 10 cycles, 3: random
  task automatic run_pass(input int mode, input int restart_at);
    int t0;
    bit got;
    foreach (mem[i]) mem[i] = 16'($urandom);
    clear_sb();
    w_ready = 1'b1;
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    got = 1'b0;
    for (int k = 1; k < 400 && !got; k++) begin
      w_ready = (mode == 0) ? 1'b1 : (mode == 1) ? k[0] : (mode == 2) ? (k > 10) : 1'($urandom_range(0, 1));
      start = (k == restart_at);
      if (mode == 2 && k == 11) begin
        chk("stall_reads", 32'(iss), 32'd2);
        chk("stall_beats", 32'(idx), 32'd0);
      end
      tick();
      got = n_done != 0;
    end
    start = 1'b0;
    if (!got) chk("timeout", 32'd0, 32'd1);
    chk("busy_after_done", 32'(busy), 32'd0);
    if (mode == 0) begin
      chk("first_valid_cyc", 32'(first_v - t0), 32'd2);
      chk("last_cyc", 32'(last_c - t0), 32'd31);
      chk("done_cyc", 32'(done_c - t0), 32'd32);
    end
    repeat (3) tick();
    chk("beats", 32'(idx), 32'(N));
    chk("reads", 32'(iss), 32'(N));
    chk("done_count", 32'(n_done), 32'd1);
  endtask

  initial begin
    int hs_c, d_c, beats;
    rst = 1'b1; start = 1'b0; w_ready = 1'b1; start1 = 1'b0; ready1 = 1'b1;
    mem_rdata = '0; mem_rdata1 = '0;
    clear_sb();
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(w_valid), 32'd0);
    chk("rst_ren", 32'(mem_ren), 32'd0);
    chk("rst_radd", 32'(mem_radd), 32'd0);
    chk("rst_data", 32'(w_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    run_pass(0, 0);
    run_pass(1, 0);
    run_pass(2, 0);
    run_pass(0, 5);
    repeat (3) run_pass(3, 0);
    // reset in the middle of a pass
    foreach (mem[i]) mem[i] = 16'($urandom);
    clear_sb();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(w_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ren", 32'(mem_ren), 32'd0);
    chk("mid_rst_radd", 32'(mem_radd), 32'd0);
    chk("mid_rst_data", 32'(w_data), 32'd0);
    chk("mid_rst_last", 32'(w_last), 32'd0);
    clear_sb();
    repeat (5) tick();
    chk("post_rst_done", 32'(n_done), 32'd0);
    chk("post_rst_beats", 32'(idx), 32'd0);
    run_pass(0, 0);
    // single-weight build
    mem1 = 16'($urandom);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    hs_c = -1; d_c = -1; beats = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (w_valid1 && ready1) begin
        chk("n1_data", 32'(w_data1), 32'(mem1));
        chk("n1_last", 32'(w_last1), 32'd1);
        hs_c = cyc;
        beats++;
      end
      if (done1) d_c = cyc;
    end
    chk("n1_beats", 32'(beats), 32'd1);
    chk("n1_done_after_hs", 32'(d_c - hs_c), 32'd1);
    chk("n1_busy_end", 32'(busy1), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
